// File: rtl/vga_sync_decoder.sv
// Receive-side VGA sync decoder: checks hsync/vsync periods, locks, and recovers x/y/active/frame_start.
// Optional sync pulse-width checking is compiled in with `define VGA_SYNC_WIDTH_CHECK_EN.
module vga_sync_decoder #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0
) (
   input  logic       clk_in,
   input  logic       reset_n,
   input  logic       pix_ce,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       locked,
   output logic       frame_start,
   output logic       err,
   output logic [1:0] dbg_state
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] XS = 10'(H_SYNC + H_BP);
   localparam logic [9:0] XE = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0] YS = 10'(V_SYNC + V_BP);
   localparam logic [9:0] YE = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

   typedef enum logic [1:0] {SEARCH = 2'd0, TRAIN = 2'd1, LOCKED = 2'd2} state_t;

   state_t     state, state_nx;
   logic       hs_in, vs_in, hs_q, vs_q, hs_prev, vs_prev, stb_q;
   logic       v_pend, v_pend_nx, h_edge, v_edge, frame_edge;
   logic [9:0] h_cnt, v_cnt, h_nx, v_nx, x_nx, y_nx;
   logic       line_err, frame_err, any_err, act_nx, fs_nx, err_nx;
   logic       w_line_err, w_frame_err;

   assign hs_in     = (SYNC_POL != 0) ? hsync : ~hsync;
   assign vs_in     = (SYNC_POL != 0) ? vsync : ~vsync;
   assign dbg_state = state;

   // Stage 1 samples on pix_ce; stb_q marks the following cycle, where stage 2 decodes that sample.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         stb_q <= 1'b0;
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
      end else begin
         stb_q <= pix_ce;
         if (pix_ce) begin
            hs_q <= hs_in;
            vs_q <= vs_in;
         end
      end
   end

`ifdef VGA_SYNC_WIDTH_CHECK_EN
   localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
   logic [9:0] hs_w, vs_w, hs_w_nx, vs_w_nx;

   // hs_w counts asserted strobes, vs_w counts H edges seen while vsync is asserted.
   always_comb begin
      hs_w_nx = hs_w;
      vs_w_nx = vs_w;
      if (h_edge)
         hs_w_nx = 10'd1;
      else if (hs_q && hs_w != 10'h3ff)
         hs_w_nx = hs_w + 10'd1;
      if (h_edge && vs_q)
         vs_w_nx = v_edge ? 10'd1 : ((vs_w != 10'h3ff) ? vs_w + 10'd1 : vs_w);
      else if (v_edge)
         vs_w_nx = 10'd0;
      w_line_err  = ~hs_q & hs_prev & (hs_w != H_SYNC_W);
      w_frame_err = ~vs_q & vs_prev & (vs_w != V_SYNC_W);
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         hs_w <= 10'd0;
         vs_w <= 10'd0;
      end else if (stb_q) begin
         hs_w <= hs_w_nx;
         vs_w <= vs_w_nx;
      end
   end
`else
   assign w_line_err  = 1'b0;
   assign w_frame_err = 1'b0;
`endif

   always_comb begin
      h_edge     = hs_q & ~hs_prev;
      v_edge     = vs_q & ~vs_prev;
      frame_edge = h_edge & (v_pend | v_edge);
      h_nx       = h_cnt;
      line_err   = 1'b0;
      if (h_edge) begin
         h_nx     = 10'd0;
         line_err = (h_cnt != H_LAST);
      end else if (h_cnt != H_TOT) begin
         h_nx     = h_cnt + 10'd1;
         line_err = (h_cnt == H_LAST);
      end
      line_err  = line_err | w_line_err;
      v_nx      = v_cnt;
      frame_err = 1'b0;
      v_pend_nx = v_pend | v_edge;
      if (h_edge) begin
         v_pend_nx = 1'b0;
         if (frame_edge) begin
            v_nx      = 10'd0;
            frame_err = (v_cnt != V_LAST);
         end else if (v_cnt != V_TOT) begin
            v_nx      = v_cnt + 10'd1;
            frame_err = (v_cnt == V_LAST);
         end
      end
      frame_err = frame_err | w_frame_err;
      any_err   = line_err | frame_err;
      state_nx  = state;
      fs_nx     = 1'b0;
      err_nx    = 1'b0;
      case (state)
         SEARCH: if (frame_edge) state_nx = TRAIN;
         TRAIN: begin
            if (any_err)         state_nx = SEARCH;
            else if (frame_edge) state_nx = LOCKED;
         end
         LOCKED: begin
            if (any_err) begin
               state_nx = SEARCH;
               err_nx   = 1'b1;
            end else if (frame_edge) begin
               fs_nx = 1'b1;
            end
         end
         default: state_nx = SEARCH;
      endcase
      // Outputs are built from the post-update counters so they appear together with the new state.
      act_nx = (h_nx >= XS) && (h_nx <= XE) && (v_nx >= YS) && (v_nx <= YE) && (state_nx == LOCKED);
      x_nx   = act_nx ? h_nx - XS : 10'd0;
      y_nx   = act_nx ? v_nx - YS : 10'd0;
   end

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         hs_prev     <= 1'b0;
         vs_prev     <= 1'b0;
         v_pend      <= 1'b0;
         h_cnt       <= 10'd0;
         v_cnt       <= 10'd0;
         state       <= SEARCH;
         x           <= 10'd0;
         y           <= 10'd0;
         active      <= 1'b0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         err         <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         err         <= 1'b0;
         if (stb_q) begin
            hs_prev     <= hs_q;
            vs_prev     <= vs_q;
            v_pend      <= v_pend_nx;
            h_cnt       <= h_nx;
            v_cnt       <= v_nx;
            state       <= state_nx;
            x           <= x_nx;
            y           <= y_nx;
            active      <= act_nx;
            locked      <= (state_nx == LOCKED);
            frame_start <= fs_nx;
            err         <= err_nx;
         end
      end
   end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 15x13 timing so whole frames run quickly.
// The built-in generator puts sync start at h=0/v=0, so decoder h_cnt/v_cnt equal the generator position.
module tb_vga_sync_decoder;
   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 6, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;   // 15
   localparam int VT = VA + VF + VS + VB;   // 13
   localparam int FRAME = HT * VT;          // 195
   localparam int XS = HS + HB, XE = HS + HB + HA - 1;
   localparam int YS = VS + VB, YE = VS + VB + VA - 1;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
   localparam int EXP_W_ERR = 1;
`else
   localparam int EXP_W_ERR = 0;
`endif

   logic       clk_in = 1'b0;
   logic       reset_n, pix_ce, hsync, vsync;
   logic [9:0] x, y;
   logic       active, locked, frame_start, err;
   logic [1:0] dbg_state;

   int n_checks = 0, n_fail = 0;
   int gh = 4, gv = 7, cur_h = 0, cur_v = 0;
   int h_total_gen = HT, hs_width_gen = HS;
   bit stuck_h = 0, chk_coord = 0;
   int err_seen = 0, fs_seen = 0, act_seen = 0;
   int fs_h = -1, fs_v = -1, first_h = -1, first_v = -1, last_h = -1, last_v = -1;
   logic [9:0] first_x, first_y, last_x, last_y;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
   ) dut (
      .clk_in(clk_in), .reset_n(reset_n), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
      .x(x), .y(y), .active(active), .locked(locked), .frame_start(frame_start),
      .err(err), .dbg_state(dbg_state)
   );

   always #10 clk_in = ~clk_in;

   // Drives one pixel (pix_ce every 2nd cycle); returns at the negedge where its result is visible.
   task automatic pix();
      logic hs_as, vs_as, exp_act;
      logic [9:0] exp_x, exp_y;
      hs_as  = !stuck_h && (gh < hs_width_gen);
      vs_as  = (gv < VS);
      hsync  = ~hs_as;
      vsync  = ~vs_as;
      pix_ce = 1'b1;
      cur_h  = gh;
      cur_v  = gv;
      @(negedge clk_in);
      pix_ce = 1'b0;
      n_checks++;
      if (err !== 1'b0 || frame_start !== 1'b0) begin
         n_fail++;
         $display("FAIL pulse_width h=%0d v=%0d: err=%b frame_start=%b, required 0 0", cur_h, cur_v, err, frame_start);
      end
      @(negedge clk_in);
      if (err === 1'b1) err_seen++;
      if (frame_start === 1'b1) begin
         fs_seen++;
         fs_h = cur_h;
         fs_v = cur_v;
      end
      if (active === 1'b1) begin
         act_seen++;
         if (first_h < 0) begin
            first_h = cur_h; first_v = cur_v; first_x = x; first_y = y;
         end
         last_h = cur_h; last_v = cur_v; last_x = x; last_y = y;
      end
      if (chk_coord) begin
         exp_act = (cur_h >= XS) && (cur_h <= XE) && (cur_v >= YS) && (cur_v <= YE);
         exp_x   = exp_act ? 10'(cur_h - XS) : 10'd0;
         exp_y   = exp_act ? 10'(cur_v - YS) : 10'd0;
         n_checks++;
         if (active !== exp_act || x !== exp_x || y !== exp_y) begin
            n_fail++;
            $display("FAIL coord h=%0d v=%0d: active=%b x=%0d y=%0d, required active=%b x=%0d y=%0d",
                     cur_h, cur_v, active, x, y, exp_act, exp_x, exp_y);
         end
      end
      gh++;
      if (gh >= h_total_gen) begin
         gh = 0;
         gv = (gv == VT - 1) ? 0 : gv + 1;
      end
   endtask

   task automatic run_to(input int h, input int v);
      for (int i = 0; i < 2 * FRAME && !(gh == h && gv == v); i++) pix();
   endtask

   task automatic check_int(input string name, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1;
      repeat (4) @(negedge clk_in);
      n_checks++;
      if (x !== 10'd0 || y !== 10'd0 || active !== 1'b0 || locked !== 1'b0 ||
          frame_start !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: x=%0d y=%0d act=%b lock=%b fs=%b err=%b st=%0d, required all 0",
                  x, y, active, locked, frame_start, err, dbg_state);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_lock();
      int edges = 0, lock_edge = -1, lock_h = -1, lock_v = -1;
      gh = 4; gv = 7; err_seen = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         pix();
         if (cur_h == 0 && cur_v == 0) edges++;
         if (locked === 1'b1) begin
            lock_edge = edges; lock_h = cur_h; lock_v = cur_v;
            break;
         end
      end
      check_int("lock_within_3_frames", int'(locked === 1'b1), 1);
      check_int("lock_on_second_frame_edge", lock_edge, 2);
      check_int("lock_position", lock_h * 100 + lock_v, 0);
      check_int("lock_state_dbg", int'(dbg_state), 2);
      check_int("lock_no_err", err_seen, 0);
   endtask

   task automatic test_window();
      chk_coord = 1;
      repeat (FRAME - 1) pix();
      act_seen = 0; fs_seen = 0; err_seen = 0; first_h = -1; fs_h = -1; fs_v = -1;
      repeat (FRAME) pix();
      check_int("active_count", act_seen, HA * VA);
      check_int("frame_start_count", fs_seen, 1);
      check_int("frame_start_pos", fs_h * 100 + fs_v, 0);
      check_int("first_active_pos", first_h * 100 + first_v, XS * 100 + YS);
      check_int("first_active_xy", int'(first_x) * 1000 + int'(first_y), 0);
      check_int("last_active_pos", last_h * 100 + last_v, XE * 100 + YE);
      check_int("last_active_xy", int'(last_x) * 1000 + int'(last_y), (HA - 1) * 1000 + (VA - 1));
      check_int("window_no_err", err_seen, 0);
   endtask

   task automatic test_pix_ce_gap();
      err_seen = 0;
      run_to(8, 7);
      pix();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_in);
         n_checks++;
         if (x !== 10'd3 || y !== 10'd2 || active !== 1'b1 || locked !== 1'b1 || err !== 1'b0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_hold cycle %0d: x=%0d y=%0d act=%b lock=%b err=%b fs=%b, required 3 2 1 1 0 0",
                     i, x, y, active, locked, err, frame_start);
         end
      end
      run_to(0, 0);
      repeat (FRAME) pix();
      check_int("gap_no_err", err_seen, 0);
      check_int("gap_still_locked", int'(locked === 1'b1), 1);
   endtask

   task automatic test_short_line();
      chk_coord = 0;
      run_to(0, 3);
      err_seen = 0;
      h_total_gen = HT - 1;
      repeat (HT - 1) pix();
      h_total_gen = HT;
      pix();
      check_int("short_err_pulse", int'(err === 1'b1), 1);
      check_int("short_unlocked", int'(locked === 1'b0 && active === 1'b0), 1);
      repeat (2 * FRAME) pix();
      check_int("short_single_err", err_seen, 1);
      check_int("short_relocked", int'(locked === 1'b1), 1);
   endtask

   task automatic test_stuck_h();
      run_to(0, 4);
      err_seen = 0;
      stuck_h = 1;
      pix();
      check_int("stuck_err_at_timeout", int'(err === 1'b1), 1);
      check_int("stuck_unlocked", int'(locked === 1'b0), 1);
      repeat (30) pix();
      check_int("stuck_single_err", err_seen, 1);
      run_to(0, 7);
      stuck_h = 0;
      for (int i = 0; i < 3 * FRAME && locked !== 1'b1; i++) pix();
      check_int("stuck_relocked", int'(locked === 1'b1), 1);
   endtask

   task automatic test_mid_reset();
      int edges = 0, premature = 0;
      chk_coord = 1;
      run_to(8, 8);
      pix();
      chk_coord = 0;
      reset_n = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if (x !== 10'd0 || y !== 10'd0 || active !== 1'b0 || locked !== 1'b0 || frame_start !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: x=%0d y=%0d act=%b lock=%b fs=%b err=%b, required all 0",
                  x, y, active, locked, frame_start, err);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         pix();
         if (cur_h == 0 && cur_v == 0) edges++;
         if (edges == 2) break;
         if (locked === 1'b1) premature = 1;
      end
      check_int("midreset_no_early_lock", premature, 0);
      check_int("midreset_relock_after_full_frame", int'(locked === 1'b1), 1);
   endtask

   task automatic test_width();
      run_to(0, 5);
      err_seen = 0;
      hs_width_gen = HS - 1;
      repeat (HT) pix();
      hs_width_gen = HS;
      check_int("width_err_count", err_seen, EXP_W_ERR);
      check_int("width_locked", int'(locked === 1'b1), 1 - EXP_W_ERR);
   endtask

   initial begin
      test_reset();
      @(negedge clk_in);
      test_lock();
      test_window();
      test_pix_ce_gap();
      test_short_line();
      test_stuck_h();
      test_mid_reset();
      test_width();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

- Receive-side counterpart to the VGA timing generator, in the same 50 MHz `clk_in` domain.
- Samples an incoming hsync/vsync pair on a one-in-N pixel strobe, checks it against configured 640x480@60 timing, and locks.
- Once locked, recovers pixel coordinates, an active-video flag and frame-start pulses.
- Used as a loopback checker for the display path and as the front end for any captured-video consumer.

## Interface
- `H_ACTIVE` 640; `H_FP` 16; `H_SYNC` 96; `H_BP` 48: horizontal timing in pixels.
- `V_ACTIVE` 480; `V_FP` 10; `V_SYNC` 2; `V_BP` 33: vertical timing in lines.
- `SYNC_POL` 0: 0 = sync active-low, 1 = active-high.
- `clk_in` in 1: 50 MHz system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `pix_ce` in 1: pixel strobe, one `clk_in` cycle per pixel (every 2nd cycle for 25 MHz).
- `hsync` in 1: horizontal sync, already synchronous to `clk_in`.
- `vsync` in 1: vertical sync, already synchronous to `clk_in`.
- `x` out 10: column 0..H_ACTIVE-1 when `active`, else 0.
- `y` out 10: row 0..V_ACTIVE-1 when `active`, else 0.
- `active` out 1: current pixel is visible and decoder is LOCKED.
- `locked` out 1: high in LOCKED state.
- `frame_start` out 1: one-cycle pulse at vertical counter reset, LOCKED only.
- `err` out 1: one-cycle pulse on a timing violation while LOCKED.

## Operation
- H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525).
- All logic advances only on cycles with `pix_ce`=1. Otherwise all registers hold, except pulses, which clear.
- **Sampling:** hsync/vsync are normalised by SYNC_POL to "asserted", then registered as `hs_q`/`vs_q` plus previous values.
- **H assertion edge:** `hs_q` asserted and previous deasserted.
- **V assertion edge:** latched into `v_pend`.
- **h_cnt (10 bit):** cleared to 0 on an H edge, else incremented.
  - Saturates at H_TOTAL; reaching H_TOTAL without an edge is a line timeout.
- **v_cnt (10 bit), updated only on H edges:**
  - `v_pend` set (or V edge in the same strobe): v_cnt←0, `v_pend` cleared. This is the "frame edge".
  - Otherwise v_cnt+1, saturating at V_TOTAL; reaching V_TOTAL is a frame timeout.
- **Line error:** H edge with h_cnt≠H_TOTAL-1, or line timeout.
- **Frame error:** frame edge with v_cnt≠V_TOTAL-1, or frame timeout.
- **FSM:**
  - SEARCH: no checking; first frame edge → TRAIN.
  - TRAIN: any line/frame error → SEARCH, no `err`. Error-free frame edge → LOCKED.
  - LOCKED: any error → `err`=1 for one cycle, then SEARCH. A frame edge pulses `frame_start`.
- **Visible window:** h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144,783] and v_cnt in [V_SYNC+V_BP, +V_ACTIVE-1] = [35,514].
- `x` = h_cnt-144, `y` = v_cnt-35, computed in 10-bit arithmetic. Both forced to 0 outside the window or when not LOCKED.

## Timing
- Reset: counters 0, `v_pend` 0, previous-sync regs deasserted, state SEARCH. All outputs 0 on the first clock after `reset_n` low.
- Latency: sync levels presented with `pix_ce` at cycle N are reflected in `x`/`y`/`active`/`locked` from N+2. That is one cycle for sampling plus one for the registered outputs.
- `frame_start` and `err` assert at N+2 for the strobe whose sample completed the edge. Both are high exactly one `clk_in` cycle.
- Error and frame edge on the same strobe: `err` wins, `frame_start` stays 0, state → SEARCH.
- Reset mid-frame: immediate return to reset values. Relock needs one SEARCH frame edge plus one full clean frame.
- Minimum lock time from reset with clean input: ≤3 frames.

## Configuration
- `VGA_SYNC_WIDTH_CHECK_EN` defined:
  - TRAIN/LOCKED also count sync pulse width. hsync must be asserted exactly H_SYNC strobes; vsync exactly V_SYNC lines, counted by H edges.
  - A mismatch counts as a line or frame error.
- Undefined: pulse widths ignored; only edge periods are checked. The width counters are not synthesised.

## Test plan
- Clean 640x480 generator with `pix_ce` every 2nd cycle, after reset → `locked`=1 by the end of the 3rd frame.
  - Once locked: first `active` has x=0,y=0 at h_cnt 144/v_cnt 35; last has x=639,y=479; `frame_start` once per 525 lines.
- Locked; one line shortened to 799 pixels → single `err` pulse, `locked`=0, `active`=0, then relock within 2 frames.
- Locked; hsync stuck deasserted → `err` when h_cnt reaches 800, then SEARCH with no further `err`.
- `reset_n`=0 for one clock mid-frame (y=200) → all outputs 0 next cycle, `locked` re-asserts only after a clean full frame.
- `pix_ce` held low 100 cycles mid-line → counters and outputs hold, no `err`; decoding resumes seamlessly.
- With `VGA_SYNC_WIDTH_CHECK_EN`, locked; hsync width 95 but period 800 → `err` pulse. Without the macro, same stimulus → no `err`.
